// File: rtl/jtdd_prom_we.sv
// Download router: steers each loader byte either to a byte lane of the 16-bit
// SDRAM or to one of PROM_W on-chip PROMs, selected by its linear file address.
//
// Ports
//   clk, rst     clock (rising edge) and asynchronous active-high reset
//   downloading  loader transfer in progress
//   ioctl_addr   byte address within the ROM file
//   ioctl_data   byte being downloaded
//   ioctl_wr     one-cycle strobe qualifying ioctl_addr/ioctl_data
//   prog_addr    SDRAM word address, or PROM byte address on PROM writes
//   prog_data    byte to write
//   prog_mask    active-low byte enables, [1]=bits 15:8, [0]=bits 7:0
//   prog_we      one-cycle SDRAM write pulse
//   prom_we      one-hot, one-cycle PROM write pulse
module jtdd_prom_we #(
    parameter int unsigned PROM_W     = 2,
    parameter int unsigned PROM_AW    = 8,
    parameter logic [21:0] BA1_START  = 22'h08000,
    parameter logic [21:0] BA2_START  = 22'h10000,
    parameter logic [21:0] BA3_START  = 22'h20000,
    parameter logic [21:0] PROM_START = 22'h40000,
    parameter logic [21:0] BA1_OFFSET = 22'h04000,
    parameter logic [21:0] BA2_OFFSET = 22'h08000,
    parameter logic [21:0] BA3_OFFSET = 22'h10000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              downloading,
    input  logic [21:0]       ioctl_addr,
    input  logic [7:0]        ioctl_data,
    input  logic              ioctl_wr,
    output logic [21:0]       prog_addr,
    output logic [7:0]        prog_data,
    output logic [1:0]        prog_mask,
    output logic              prog_we,
    output logic [PROM_W-1:0] prom_we
);

    localparam int unsigned AW = 22;
    // Total bytes occupied by all PROMs after PROM_START
    localparam logic [AW-1:0] PROM_TOTAL = AW'(PROM_W) << PROM_AW;

    logic [AW-1:0]     region_base_c;
    logic [AW-1:0]     region_off_c;
    logic [AW-1:0]     prom_off_c;
    logic [AW-1:0]     sdram_addr_c;
    logic [PROM_W-1:0] prom_sel_c;
    logic              sdram_hit_c;
    logic              prom_hit_c;
    logic              accept_c;

    // Address decode: region start/offset selection and PROM range check
    always_comb begin
        region_base_c = '0;
        region_off_c  = '0;
        sdram_hit_c   = 1'b0;
        prom_hit_c    = 1'b0;
        prom_off_c    = ioctl_addr - PROM_START;
        if (ioctl_addr < BA1_START) begin
            sdram_hit_c = 1'b1;
        end else if (ioctl_addr < BA2_START) begin
            region_base_c = BA1_START;
            region_off_c  = BA1_OFFSET;
            sdram_hit_c   = 1'b1;
        end else if (ioctl_addr < BA3_START) begin
            region_base_c = BA2_START;
            region_off_c  = BA2_OFFSET;
            sdram_hit_c   = 1'b1;
        end else if (ioctl_addr < PROM_START) begin
            region_base_c = BA3_START;
            region_off_c  = BA3_OFFSET;
            sdram_hit_c   = 1'b1;
        end else if (prom_off_c < PROM_TOTAL) begin
            prom_hit_c = 1'b1;
        end
    end

    // Byte address to word address, wrapping modulo 2**22
    assign sdram_addr_c = ((ioctl_addr - region_base_c) >> 1) + region_off_c;
    assign prom_sel_c   = PROM_W'(1) << (prom_off_c >> PROM_AW);
    assign accept_c     = ioctl_wr & downloading;

    // Output registers; write pulses clear every cycle unless re-armed
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prog_addr <= '0;
            prog_data <= '0;
            prog_mask <= 2'b11;
            prog_we   <= 1'b0;
            prom_we   <= '0;
        end else begin
            prog_we <= 1'b0;
            prom_we <= '0;
            if (accept_c && sdram_hit_c) begin
                prog_data <= ioctl_data;
                prog_addr <= sdram_addr_c;
                // Even byte goes to the low lane, odd byte to the high lane
                prog_mask <= ioctl_addr[0] ? 2'b01 : 2'b10;
                prog_we   <= 1'b1;
            end else if (accept_c && prom_hit_c) begin
                prog_data <= ioctl_data;
                prog_addr <= AW'(prom_off_c[PROM_AW-1:0]);
                prog_mask <= 2'b11;
                prom_we   <= prom_sel_c;
            end
        end
    end

endmodule

// File: tb/tb_jtdd_prom_we.sv
module tb_jtdd_prom_we;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        downloading = 1'b0;
    logic [21:0] ioctl_addr = '0;
    logic [7:0]  ioctl_data = '0;
    logic        ioctl_wr = 1'b0;
    logic [21:0] prog_addr;
    logic [7:0]  prog_data;
    logic [1:0]  prog_mask;
    logic        prog_we;
    logic [1:0]  prom_we;

    int n_checks = 0;
    int n_pass   = 0;
    int n_pulse  = 0;
    int n_bad    = 0;

    logic [15:0] sdram_cap [int];
    logic [15:0] exp_sdram [int];
    logic [7:0]  prom_cap  [2][256];
    logic [15:0] mon_w;

    jtdd_prom_we dut (
        .clk         (clk),
        .rst         (rst),
        .downloading (downloading),
        .ioctl_addr  (ioctl_addr),
        .ioctl_data  (ioctl_data),
        .ioctl_wr    (ioctl_wr),
        .prog_addr   (prog_addr),
        .prog_data   (prog_data),
        .prog_mask   (prog_mask),
        .prog_we     (prog_we),
        .prom_we     (prom_we)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    // Reference address map written out from the region table
    function automatic logic [21:0] exp_word(input logic [21:0] a);
        if (a < 22'h08000)      return a >> 1;
        else if (a < 22'h10000) return 22'((a - 22'h08000) >> 1) + 22'h04000;
        else if (a < 22'h20000) return 22'((a - 22'h10000) >> 1) + 22'h08000;
        else                    return 22'((a - 22'h20000) >> 1) + 22'h10000;
    endfunction

    function automatic logic [7:0] file_byte(input logic [21:0] a);
        return 8'(a) ^ 8'(a >> 8) ^ 8'(a >> 16) ^ 8'h5A;
    endfunction

    // Capture every write pulse into the SDRAM / PROM images
    always @(negedge clk) begin
        if (prog_we) begin
            mon_w = sdram_cap.exists(int'(prog_addr)) ? sdram_cap[int'(prog_addr)] : 16'h0000;
            if (!prog_mask[0]) mon_w[7:0]  = prog_data;
            if (!prog_mask[1]) mon_w[15:8] = prog_data;
            sdram_cap[int'(prog_addr)] = mon_w;
            n_pulse++;
        end
        if (prom_we != 2'b00) begin
            prom_cap[prom_we[1] ? 1 : 0][prog_addr[7:0]] = prog_data;
            n_pulse++;
        end
        if ($countones(prom_we) > 1 || (prog_we && prom_we != 2'b00)) n_bad++;
    end

    // One strobe, then sample right after the capturing edge
    task automatic send(input logic [21:0] a, input logic [7:0] d, input logic dl);
        @(negedge clk);
        ioctl_addr  = a;
        ioctl_data  = d;
        ioctl_wr    = 1'b1;
        downloading = dl;
        @(negedge clk);
        ioctl_wr = 1'b0;
        #1;
    endtask

    task automatic expect_idle(input string tag);
        @(negedge clk);
        #1;
        check({tag, "_we_low"}, 32'(prog_we), 32'h0);
        check({tag, "_prom_low"}, 32'(prom_we), 32'h0);
    endtask

    // Boundary table: address, expected prog_addr, mask, prog_we, prom_we
    logic [21:0] b_addr [12] = '{22'h07FFF, 22'h08000, 22'h0FFFF, 22'h10000,
                                 22'h1FFFF, 22'h20000, 22'h3FFFF, 22'h40000,
                                 22'h400FF, 22'h40100, 22'h401FF, 22'h08002};
    logic [21:0] b_pa   [12] = '{22'h03FFF, 22'h04000, 22'h07FFF, 22'h08000,
                                 22'h0FFFF, 22'h10000, 22'h1FFFF, 22'h00000,
                                 22'h000FF, 22'h00000, 22'h000FF, 22'h04001};
    logic [1:0]  b_mask [12] = '{2'b01, 2'b10, 2'b01, 2'b10, 2'b01, 2'b10,
                                 2'b01, 2'b11, 2'b11, 2'b11, 2'b11, 2'b10};
    logic        b_we   [12] = '{1, 1, 1, 1, 1, 1, 1, 0, 0, 0, 0, 1};
    logic [1:0]  b_prom [12] = '{2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00,
                                 2'b00, 2'b01, 2'b01, 2'b10, 2'b10, 2'b00};
    logic [21:0] win    [8]  = '{22'h00000, 22'h07FE0, 22'h08000, 22'h0FFE0,
                                 22'h10000, 22'h1FFE0, 22'h20000, 22'h3FFE0};

    initial begin
        logic [21:0] a;
        logic [7:0]  d;
        logic [15:0] w;
        int          k;

        // Reset values while rst is held
        #12;
        check("rst_addr", 32'(prog_addr), 32'h0);
        check("rst_data", 32'(prog_data), 32'h0);
        check("rst_mask", 32'(prog_mask), 32'h3);
        check("rst_we",   32'(prog_we),   32'h0);
        check("rst_prom", 32'(prom_we),   32'h0);
        @(negedge clk);
        rst = 1'b0;

        // Two bytes forming SDRAM word 0
        send(22'h00000, 8'h12, 1'b1);
        check("b0_we",   32'(prog_we),   32'h1);
        check("b0_addr", 32'(prog_addr), 32'h0);
        check("b0_mask", 32'(prog_mask), 32'h2);
        check("b0_data", 32'(prog_data), 32'h12);
        expect_idle("b0");
        send(22'h00001, 8'h34, 1'b1);
        check("b1_we",   32'(prog_we),   32'h1);
        check("b1_addr", 32'(prog_addr), 32'h0);
        check("b1_mask", 32'(prog_mask), 32'h1);
        expect_idle("b1");
        check("word0", sdram_cap.exists(0) ? 32'(sdram_cap[0]) : 32'hDEAD, 32'h3412);

        // PROM 1 write
        send(22'h40105, 8'hA5, 1'b1);
        check("prom_sel",  32'(prom_we),   32'h2);
        check("prom_addr", 32'(prog_addr), 32'h05);
        check("prom_data", 32'(prog_data), 32'hA5);
        check("prom_nowe", 32'(prog_we),   32'h0);
        expect_idle("prom");

        // Beyond the last PROM, and strobe without downloading
        send(22'h40200, 8'h77, 1'b1);
        check("oor_we",   32'(prog_we),   32'h0);
        check("oor_prom", 32'(prom_we),   32'h0);
        check("oor_hold", 32'(prog_addr), 32'h05);
        send(22'h00010, 8'h99, 1'b0);
        check("nodl_we",   32'(prog_we),   32'h0);
        check("nodl_prom", 32'(prom_we),   32'h0);
        check("nodl_data", 32'(prog_data), 32'hA5);

        // Region boundaries
        for (int i = 0; i < 12; i++) begin
            send(b_addr[i], 8'(i), 1'b1);
            check($sformatf("bnd%0d_addr", i), 32'(prog_addr), 32'(b_pa[i]));
            check($sformatf("bnd%0d_mask", i), 32'(prog_mask), 32'(b_mask[i]));
            check($sformatf("bnd%0d_we", i),   32'(prog_we),   32'(b_we[i]));
            check($sformatf("bnd%0d_prom", i), 32'(prom_we),   32'(b_prom[i]));
        end
        expect_idle("bnd");

        // Back-to-back strobes produce back-to-back pulses
        @(negedge clk);
        ioctl_addr = 22'h00100; ioctl_wr = 1'b1; downloading = 1'b1;
        @(negedge clk);
        #1;
        check("b2b_first", 32'(prog_we), 32'h1);
        ioctl_addr = 22'h00101;
        @(negedge clk);
        ioctl_wr = 1'b0;
        #1;
        check("b2b_second", 32'(prog_we), 32'h1);
        check("b2b_mask",   32'(prog_mask), 32'h1);
        expect_idle("b2b");

        // Async reset while a pulse is high
        @(negedge clk);
        ioctl_addr = 22'h40001; ioctl_wr = 1'b1;
        @(posedge clk);
        #2;
        check("pre_rst_prom", 32'(prom_we), 32'h1);
        rst = 1'b1;
        #1;
        check("arst_prom", 32'(prom_we),   32'h0);
        check("arst_we",   32'(prog_we),   32'h0);
        check("arst_mask", 32'(prog_mask), 32'h3);
        check("arst_addr", 32'(prog_addr), 32'h0);
        @(negedge clk);
        ioctl_wr = 1'b0;
        rst = 1'b0;

        // File stream, one strobe every 4 clocks
        @(negedge clk);
        sdram_cap.delete();
        n_pulse = 0;
        n_bad   = 0;
        for (int wi = 0; wi < 8; wi++) begin
            for (int i = 0; i < 32; i++) begin
                a = win[wi] + 22'(i);
                d = file_byte(a);
                k = int'(exp_word(a));
                w = exp_sdram.exists(k) ? exp_sdram[k] : 16'h0000;
                if (a[0]) w[15:8] = d;
                else      w[7:0]  = d;
                exp_sdram[k] = w;
                @(negedge clk);
                ioctl_addr = a; ioctl_data = d; ioctl_wr = 1'b1;
                @(negedge clk);
                ioctl_wr = 1'b0;
                repeat (2) @(negedge clk);
            end
        end
        for (int i = 0; i < 516; i++) begin
            a = 22'h40000 + 22'(i);
            @(negedge clk);
            ioctl_addr = a; ioctl_data = file_byte(a); ioctl_wr = 1'b1;
            @(negedge clk);
            ioctl_wr = 1'b0;
            repeat (2) @(negedge clk);
        end
        repeat (2) @(negedge clk);
        #1;
        check("stream_pulses", 32'(n_pulse), 32'd768);
        check("stream_onehot", 32'(n_bad), 32'd0);
        check("stream_words", 32'(sdram_cap.num()), 32'(exp_sdram.num()));
        foreach (exp_sdram[key])
            check($sformatf("sdram_%05h", key),
                  sdram_cap.exists(key) ? 32'(sdram_cap[key]) : 32'hDEAD,
                  32'(exp_sdram[key]));
        for (int p = 0; p < 2; p++)
            for (int i = 0; i < 256; i++)
                check($sformatf("prom%0d_%02h", p, i), 32'(prom_cap[p][i]),
                      32'(file_byte(22'h40000 + 22'(p * 256 + i))));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
